flash_seq_ctrl: RTL and testbench

FLASH_SEQ_CTRL -- requirements
Module: flash_seq_ctrl

---
 rtl/flash_seq_ctrl.sv | 195 +++++++++++++++++++
 tb/tb_flash_seq_ctrl.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/flash_seq_ctrl.sv
// Sequences SPI-flash read-ID, page read, sector erase and page program (WREN, op, status polls).
// Define FLASH_SEQ_TIMEOUT_EN to bound status polling at POLL_MAX and report err on timeout.
module flash_seq_ctrl #(
  parameter logic [15:0] POLL_MAX    = 16'd50000,
  parameter int          SR_BUSY_BIT = 0
) (
  input  logic        clock24M,
  input  logic        flash_rst,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic [23:0] addr,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [15:0] id_out,
  output logic [7:0]  rd_data,
  output logic        rd_valid,
  output logic [3:0]  cmd_type,
  output logic [7:0]  flash_cmd,
  output logic [23:0] flash_addr,
  input  logic        Done_Sig,
  input  logic [7:0]  mydata_o,
  input  logic        myvalid_o,
  output logic [2:0]  seq_state
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_WREN   = 3'd1,
    S_WREN_W = 3'd2,
    S_OP     = 3'd3,
    S_OP_W   = 3'd4,
    S_POLL   = 3'd5,
    S_POLL_W = 3'd6,
    S_FINISH = 3'd7
  } state_t;

  localparam logic [1:0] OP_RDID = 2'b00;
  localparam logic [1:0] OP_READ = 2'b01;

  localparam logic [2:0] T_WREN = 3'b001;
  localparam logic [2:0] T_RDSR = 3'b011;
  localparam logic [7:0] C_WREN = 8'h06;
  localparam logic [7:0] C_RDSR = 8'h05;

  state_t      r_state;
  logic [1:0]  r_op;
  logic [23:0] r_addr;
  logic        r_busy;
  logic        r_done;
  logic [15:0] r_id;
  logic [1:0]  r_id_cnt;
  logic        r_sr_busy;
  logic [3:0]  r_cmd_type;
  logic [7:0]  r_flash_cmd;
  logic [23:0] r_flash_addr;
  logic        w_rd_valid;
  logic        w_sr_busy;
`ifdef FLASH_SEQ_TIMEOUT_EN
  logic        r_err;
  logic [15:0] r_poll_cnt;
`endif

  // {type, cmd, addr} of the main operation for a given opcode
  function automatic logic [34:0] op_cmd(input logic [1:0] o, input logic [23:0] a);
    case (o)
      2'b00:   op_cmd = {3'b000, 8'h90, 24'h000000};
      2'b01:   op_cmd = {3'b110, 8'h03, a};
      2'b10:   op_cmd = {3'b010, 8'h20, a};
      default: op_cmd = {3'b101, 8'h02, a};
    endcase
  endfunction

  assign w_rd_valid = (r_state == S_OP_W) && (r_op == OP_READ) && myvalid_o;
  // Status byte may arrive in the same cycle as Done_Sig, so look through the capture register.
  assign w_sr_busy  = myvalid_o ? mydata_o[SR_BUSY_BIT] : r_sr_busy;

  always_ff @(posedge clock24M or posedge flash_rst) begin
    if (flash_rst) begin
      r_state      <= S_IDLE;
      r_op         <= 2'b00;
      r_addr       <= 24'h000000;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_id         <= 16'h0000;
      r_id_cnt     <= 2'd0;
      r_sr_busy    <= 1'b0;
      r_cmd_type   <= 4'h0;
      r_flash_cmd  <= 8'h00;
      r_flash_addr <= 24'h000000;
`ifdef FLASH_SEQ_TIMEOUT_EN
      r_err        <= 1'b0;
      r_poll_cnt   <= 16'h0000;
`endif
    end else begin
      r_done        <= 1'b0;
      r_cmd_type[3] <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_op     <= op;
            r_addr   <= addr;
            r_busy   <= 1'b1;
            r_id_cnt <= 2'd0;
`ifdef FLASH_SEQ_TIMEOUT_EN
            r_err    <= 1'b0;
`endif
            if (op[1]) begin
              r_state <= S_WREN;
              {r_cmd_type, r_flash_cmd, r_flash_addr} <= {1'b1, T_WREN, C_WREN, 24'h000000};
`ifdef FLASH_SEQ_TIMEOUT_EN
              r_poll_cnt <= 16'h0000;
`endif
            end else begin
              r_state <= S_OP;
              {r_cmd_type, r_flash_cmd, r_flash_addr} <= {1'b1, op_cmd(op, addr)};
            end
          end
        end
        S_WREN: r_state <= S_WREN_W;
        S_WREN_W: begin
          if (Done_Sig) begin
            r_state <= S_OP;
            {r_cmd_type, r_flash_cmd, r_flash_addr} <= {1'b1, op_cmd(r_op, r_addr)};
          end
        end
        S_OP: r_state <= S_OP_W;
        S_OP_W: begin
          if (myvalid_o && (r_op == OP_RDID) && (r_id_cnt != 2'd2)) begin
            if (r_id_cnt == 2'd0) r_id[15:8] <= mydata_o;
            else                  r_id[7:0]  <= mydata_o;
            r_id_cnt <= r_id_cnt + 2'd1;
          end
          if (Done_Sig) begin
            if (r_op[1]) begin
              r_state <= S_POLL;
              {r_cmd_type, r_flash_cmd, r_flash_addr} <= {1'b1, T_RDSR, C_RDSR, 24'h000000};
            end else begin
              r_state <= S_FINISH;
              r_done  <= 1'b1;
              r_busy  <= 1'b0;
            end
          end
        end
        S_POLL: begin
          r_state <= S_POLL_W;
`ifdef FLASH_SEQ_TIMEOUT_EN
          r_poll_cnt <= r_poll_cnt + 16'd1;
`endif
        end
        S_POLL_W: begin
          if (myvalid_o) r_sr_busy <= mydata_o[SR_BUSY_BIT];
          if (Done_Sig) begin
            if (!w_sr_busy) begin
              r_state <= S_FINISH;
              r_done  <= 1'b1;
              r_busy  <= 1'b0;
`ifdef FLASH_SEQ_TIMEOUT_EN
            end else if (r_poll_cnt >= POLL_MAX) begin
              r_state <= S_FINISH;
              r_done  <= 1'b1;
              r_busy  <= 1'b0;
              r_err   <= 1'b1;
`endif
            end else begin
              r_state <= S_POLL;
              {r_cmd_type, r_flash_cmd, r_flash_addr} <= {1'b1, T_RDSR, C_RDSR, 24'h000000};
            end
          end
        end
        S_FINISH: r_state <= S_IDLE;
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign busy       = r_busy;
  assign done       = r_done;
  assign id_out     = r_id;
  assign rd_valid   = w_rd_valid;
  assign rd_data    = w_rd_valid ? mydata_o : 8'h00;
  assign cmd_type   = r_cmd_type;
  assign flash_cmd  = r_flash_cmd;
  assign flash_addr = r_flash_addr;
  assign seq_state  = r_state;
`ifdef FLASH_SEQ_TIMEOUT_EN
  assign err        = r_err;
`else
  assign err        = 1'b0;
`endif

endmodule

// File: tb/tb_flash_seq_ctrl.sv
// Scoreboard bench for flash_seq_ctrl with a behavioural SPI-engine responder.
module tb_flash_seq_ctrl;

  logic        clk = 1'b0;
  logic        flash_rst;
  logic        start;
  logic [1:0]  op;
  logic [23:0] addr;
  logic        busy, done, err, rd_valid;
  logic [15:0] id_out;
  logic [7:0]  rd_data, flash_cmd, mydata_o;
  logic [3:0]  cmd_type;
  logic [23:0] flash_addr;
  logic        Done_Sig, myvalid_o;
  logic [2:0]  seq_state;

  int n_tot = 0;
  int n_bad = 0;

  logic [34:0] q_cmd[$];
  logic [7:0]  q_rd[$];
  logic [17:0] q_done[$];
  logic [7:0]  st_q[$];
  logic [7:0]  st_def;
  bit          m_slow;

  always #5 clk = ~clk;

  flash_seq_ctrl #(.POLL_MAX(16'd4), .SR_BUSY_BIT(0)) dut (
    .clock24M(clk), .flash_rst(flash_rst), .start(start), .op(op), .addr(addr),
    .busy(busy), .done(done), .err(err), .id_out(id_out), .rd_data(rd_data),
    .rd_valid(rd_valid), .cmd_type(cmd_type), .flash_cmd(flash_cmd),
    .flash_addr(flash_addr), .Done_Sig(Done_Sig), .mydata_o(mydata_o),
    .myvalid_o(myvalid_o), .seq_state(seq_state)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tot++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  // SPI engine responder
  task automatic m_step(input logic v, input logic [7:0] d, input logic dn, inout bit ab);
    if (ab) begin
      myvalid_o = 1'b0; mydata_o = 8'h00; Done_Sig = 1'b0;
      return;
    end
    @(negedge clk);
    if (flash_rst) ab = 1'b1;
    if (ab) begin
      myvalid_o = 1'b0; mydata_o = 8'h00; Done_Sig = 1'b0;
    end else begin
      myvalid_o = v; mydata_o = d; Done_Sig = dn;
    end
  endtask

  initial begin
    bit          ab;
    logic [7:0]  c, s;
    Done_Sig = 1'b0; myvalid_o = 1'b0; mydata_o = 8'h00;
    forever begin
      @(negedge clk);
      myvalid_o = 1'b0; Done_Sig = 1'b0; mydata_o = 8'h00;
      if (cmd_type[3] && !flash_rst) begin
        ab = 1'b0;
        c  = flash_cmd;
        case (c)
          8'h90: begin
            m_step(1'b0, 8'h00, 1'b0, ab);
            m_step(1'b1, 8'hEF, 1'b0, ab);
            m_step(1'b1, 8'h16, 1'b0, ab);
            m_step(1'b1, 8'hAA, 1'b0, ab);
            m_step(1'b0, 8'h00, 1'b1, ab);
          end
          8'h03: begin
            m_step(1'b0, 8'h00, 1'b0, ab);
            for (int i = 0; i < 256; i++) m_step(1'b1, i[7:0], 1'b0, ab);
            m_step(1'b0, 8'h00, 1'b1, ab);
          end
          8'h05: begin
            s = (st_q.size() != 0) ? st_q.pop_front() : st_def;
            repeat (m_slow ? 20 : 1) m_step(1'b0, 8'h00, 1'b0, ab);
            m_step(1'b1, s, 1'b0, ab);
            m_step(1'b0, 8'h00, 1'b1, ab);
          end
          default: begin
            m_step(1'b0, 8'h00, 1'b0, ab);
            m_step(1'b0, 8'h00, 1'b1, ab);
          end
        endcase
      end
    end
  end

  // Output monitor: pops scoreboard entries as the DUT produces events
  initial begin
    bit          prev_cmd, prev_done;
    logic [7:0]  last_cmd;
    logic [34:0] ec;
    logic [7:0]  er;
    logic [17:0] ed;
    prev_cmd = 1'b0; prev_done = 1'b0; last_cmd = 8'h00;
    forever begin
      @(negedge clk); #1;
      if (!flash_rst) begin
        if (cmd_type[3]) begin
          chk("cmd_width", prev_cmd, 0);
          last_cmd = flash_cmd;
          if (q_cmd.size() == 0) chk("cmd_unexpected", q_cmd.size(), 1);
          else begin
            ec = q_cmd.pop_front();
            chk("cmd", {cmd_type[2:0], flash_cmd, flash_addr}, ec);
          end
        end
        if (Done_Sig) chk("cmd_hold", flash_cmd, last_cmd);
        if (rd_valid) begin
          if (q_rd.size() == 0) chk("rd_unexpected", q_rd.size(), 1);
          else begin
            er = q_rd.pop_front();
            chk("rd_data", rd_data, er);
          end
        end
        if (done) begin
          chk("done_width", prev_done, 0);
          chk("busy_at_done", busy, 0);
          if (q_done.size() == 0) chk("done_unexpected", q_done.size(), 1);
          else begin
            ed = q_done.pop_front();
            chk("err", err, ed[16]);
            if (ed[17]) chk("id_out", id_out, ed[15:0]);
          end
        end
      end
      prev_cmd  = cmd_type[3];
      prev_done = done;
    end
  end

  task automatic do_start(input logic [1:0] o, input logic [23:0] a);
    @(negedge clk);
    start = 1'b1; op = o; addr = a;
    @(negedge clk);
    start = 1'b0;
    chk("busy_after_start", busy, 1);
  endtask

  task automatic wait_done(input int max);
    int n;
    n = 0;
    while (!done && n < max) begin
      @(negedge clk);
      n++;
    end
    if (!done) chk("done_timeout", done, 1);
  endtask

  task automatic chk_reset_outs(input string tag);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_err"}, err, 0);
    chk({tag, "_rd_valid"}, rd_valid, 0);
    chk({tag, "_rd_data"}, rd_data, 0);
    chk({tag, "_cmd_type"}, cmd_type, 0);
    chk({tag, "_flash_cmd"}, flash_cmd, 0);
    chk({tag, "_flash_addr"}, flash_addr, 0);
    chk({tag, "_id_out"}, id_out, 0);
    chk({tag, "_state"}, seq_state, 0);
  endtask

  initial begin
    int n;
    flash_rst = 1'b1; start = 1'b0; op = 2'b00; addr = 24'h0;
    st_def = 8'h00; m_slow = 1'b0;
    repeat (3) @(negedge clk);
    chk_reset_outs("rst");
    flash_rst = 1'b0;

    // read ID; supplied addr must not reach the engine
    q_cmd.push_back({3'b000, 8'h90, 24'h000000});
    q_done.push_back({1'b1, 1'b0, 16'hEF16});
    do_start(2'b00, 24'hABCDEF);
    wait_done(500);

    // read page
    q_cmd.push_back({3'b110, 8'h03, 24'h001000});
    for (int i = 0; i < 256; i++) q_rd.push_back(i[7:0]);
    q_done.push_back({1'b0, 1'b0, 16'h0000});
    do_start(2'b01, 24'h001000);
    wait_done(1000);

    // page program, two busy polls then ready
    st_q = '{8'h01, 8'h01, 8'h00};
    q_cmd.push_back({3'b001, 8'h06, 24'h000000});
    q_cmd.push_back({3'b101, 8'h02, 24'h002000});
    repeat (3) q_cmd.push_back({3'b011, 8'h05, 24'h000000});
    q_done.push_back({1'b0, 1'b0, 16'h0000});
    do_start(2'b11, 24'h002000);
    wait_done(500);

    // sector erase with start held high and op/addr disturbed mid-sequence
    q_cmd.push_back({3'b001, 8'h06, 24'h000000});
    q_cmd.push_back({3'b010, 8'h20, 24'h003000});
`ifdef FLASH_SEQ_TIMEOUT_EN
    st_def = 8'h01;
    repeat (4) q_cmd.push_back({3'b011, 8'h05, 24'h000000});
    q_done.push_back({1'b0, 1'b1, 16'h0000});
`else
    st_q = '{8'h01, 8'h01, 8'h01, 8'h01, 8'h01, 8'h00};
    repeat (6) q_cmd.push_back({3'b011, 8'h05, 24'h000000});
    q_done.push_back({1'b0, 1'b0, 16'h0000});
`endif
    @(negedge clk);
    start = 1'b1; op = 2'b10; addr = 24'h003000;
    @(negedge clk);
    op = 2'b00; addr = 24'hFFFFFF;
    wait_done(800);
    start = 1'b0;
    repeat (3) @(negedge clk);
    chk("idle_after_held_start", seq_state, 0);
    chk("busy_after_held_start", busy, 0);
`ifdef FLASH_SEQ_TIMEOUT_EN
    chk("err_held", err, 1);
`endif
    st_def = 8'h00;

    // reset while waiting on a status poll
    m_slow = 1'b1;
    q_cmd.push_back({3'b001, 8'h06, 24'h000000});
    q_cmd.push_back({3'b101, 8'h02, 24'h004000});
    q_cmd.push_back({3'b011, 8'h05, 24'h000000});
    do_start(2'b11, 24'h004000);
    n = 0;
    while (seq_state != 3'd6 && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("reach_poll_w", seq_state, 6);
    @(negedge clk);
    flash_rst = 1'b1;
    #1;
    chk_reset_outs("midrst");
    repeat (2) @(negedge clk);
    flash_rst = 1'b0;
    m_slow = 1'b0;
    chk("cmd_q_after_rst", q_cmd.size(), 0);

    q_cmd.push_back({3'b000, 8'h90, 24'h000000});
    q_done.push_back({1'b1, 1'b0, 16'hEF16});
    do_start(2'b00, 24'h000000);
    wait_done(500);
    repeat (4) @(negedge clk);

    chk("cmd_q_empty", q_cmd.size(), 0);
    chk("rd_q_empty", q_rd.size(), 0);
    chk("done_q_empty", q_done.size(), 0);
    $display("test done: total=%0d bad=%0d", n_tot, n_bad);
    $finish;
  end

endmodule
